i2c_burst_sequencer: RTL and testbench

- Parametrised successor to the single-shot I2C sequencer. Converts I2C slave byte strobes into register-bus transactions, with auto-incrementing burst writes and burst reads, bus-side acknowledge, timeout, and a one-deep write skid buffer.
- Sits between the I2C slave front end (addr_xfc, data_xfc, stop_out, i2c_RW) and the on-chip register/memory bus.

---
 rtl/i2c_seq_pkg.sv | 16 +
 rtl/i2c_burst_sequencer_edge.sv | 22 ++
 rtl/i2c_burst_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_i2c_burst_sequencer.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_seq_pkg.sv
// Shared types and constants for the I2C burst sequencer.
package i2c_seq_pkg;
  localparam int DEF_AW = 11;
  localparam int DEF_DW = 8;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_WAIT = 3'd1,
    ST_WR_BUSY = 3'd2,
    ST_RD_BUSY = 3'd3,
    ST_RD_HOLD = 3'd4
  } state_t;
endpackage

// File: rtl/i2c_burst_sequencer_edge.sv
// Registered rising-edge detector; history resets high so a strobe held through reset is ignored.
module i2c_edge_detect (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_level,
  output logic o_pulse
);
  logic r_prev;
  logic r_pulse;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_prev  <= 1'b1;
      r_pulse <= 1'b0;
    end else begin
      r_prev  <= i_level;
      r_pulse <= i_level & ~r_prev;
    end
  end

  assign o_pulse = r_pulse;
endmodule

// File: rtl/i2c_burst_sequencer.sv
// Turns I2C slave byte strobes into auto-incrementing register-bus bursts with
// acknowledge, timeout and a one-deep write skid buffer.
module i2c_burst_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int AW          = DEF_AW,
  parameter int DW          = DEF_DW,
  parameter int ADDR_MAX    = 2**AW - 1,
  parameter int WRAP        = 1,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic          Clock,
  input  logic          reset,
  input  logic          i2c_RW,
  input  logic [AW-1:0] i2c_addr_in,
  input  logic [DW-1:0] i2c_data_in,
  input  logic          addr_xfc,
  input  logic          data_xfc,
  input  logic          stop_out,
  input  logic          bus_ack,
  input  logic [DW-1:0] bus_rdata,
  output logic          i2c_op,
  output logic [AW-1:0] i2c_addr_out,
  output logic [DW-1:0] i2c_data_out,
  output logic          i2c_xfc,
  output logic [DW-1:0] i2c_rdata,
  output logic          i2c_rvalid,
  output logic          busy,
  output logic          err
);
  localparam int            TW          = $clog2(ACK_TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST    = TW'(ACK_TIMEOUT - 1);
  localparam logic [AW-1:0] LP_ADDR_MAX = AW'(ADDR_MAX);

  state_t        r_state;
  logic [AW-1:0] r_ptr;
  logic          r_err;
  logic          r_stop_pend;
  logic          r_skid_full;
  logic [DW-1:0] r_skid_data;
  logic          r_issue;
  logic          r_issue_op;
  logic [DW-1:0] r_issue_data;
  logic          r_op;
  logic [AW-1:0] r_addr_out;
  logic [DW-1:0] r_data_out;
  logic          r_xfc;
  logic [DW-1:0] r_rdata;
  logic          r_rvalid;
  logic [TW-1:0] r_tcnt;

  logic          w_addr_pulse;
  logic          w_data_pulse;
  logic          w_addr_edge;
  logic          w_data_edge;
  logic          w_ack;
  logic          w_timeout;
  logic [AW:0]   w_inc;

  // Returns {saturated, next pointer}.
  function automatic logic [AW:0] f_ptr_inc(input logic [AW-1:0] p);
    if (p >= LP_ADDR_MAX) begin
      if (WRAP != 0) return {1'b0, {AW{1'b0}}};
      return {1'b1, LP_ADDR_MAX};
    end
    return {1'b0, p + 1'b1};
  endfunction

  i2c_edge_detect u_addr_edge (
    .i_clk  (Clock),
    .i_rst_n(reset),
    .i_level(addr_xfc),
    .o_pulse(w_addr_pulse)
  );

  i2c_edge_detect u_data_edge (
    .i_clk  (Clock),
    .i_rst_n(reset),
    .i_level(data_xfc),
    .o_pulse(w_data_pulse)
  );

  assign w_addr_edge = w_addr_pulse;
  assign w_data_edge = w_data_pulse & ~w_addr_pulse;
  assign w_ack       = r_xfc & bus_ack;
  assign w_timeout   = r_xfc & ~bus_ack & (r_tcnt == TMO_LAST);
  assign w_inc       = f_ptr_inc(r_ptr);

  always_ff @(posedge Clock) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_ptr        <= '0;
      r_err        <= 1'b0;
      r_stop_pend  <= 1'b0;
      r_skid_full  <= 1'b0;
      r_skid_data  <= '0;
      r_issue      <= 1'b0;
      r_issue_op   <= OP_READ;
      r_issue_data <= '0;
      r_op         <= 1'b0;
      r_addr_out   <= '0;
      r_data_out   <= '0;
      r_xfc        <= 1'b0;
      r_rdata      <= '0;
      r_rvalid     <= 1'b0;
      r_tcnt       <= '0;
    end else begin
      r_issue  <= 1'b0;
      r_rvalid <= 1'b0;

      // Bus request stage: launch one cycle after the decision, hold until ack or timeout.
      if (r_issue) begin
        r_xfc      <= 1'b1;
        r_op       <= r_issue_op;
        r_addr_out <= r_ptr;
        r_data_out <= (r_issue_op == OP_WRITE) ? r_issue_data : '0;
        r_tcnt     <= '0;
      end else if (w_ack || w_timeout) begin
        r_xfc      <= 1'b0;
        r_addr_out <= '0;
        r_data_out <= '0;
        r_tcnt     <= '0;
      end else if (r_xfc) begin
        r_tcnt <= r_tcnt + 1'b1;
      end

      case (r_state)
        ST_IDLE, ST_WR_WAIT, ST_RD_HOLD: begin
          if (w_addr_edge) begin
            r_ptr       <= i2c_addr_in;
            r_err       <= 1'b0;
            r_stop_pend <= 1'b0;
            if (i2c_RW) begin
              r_state <= ST_WR_WAIT;
            end else begin
              r_state      <= ST_RD_BUSY;
              r_issue      <= 1'b1;
              r_issue_op   <= OP_READ;
              r_issue_data <= '0;
            end
          end else if (stop_out) begin
            r_state <= ST_IDLE;
          end else if (w_data_edge && r_state == ST_WR_WAIT) begin
            r_state      <= ST_WR_BUSY;
            r_issue      <= 1'b1;
            r_issue_op   <= OP_WRITE;
            r_issue_data <= i2c_data_in;
          end else if (w_data_edge && r_state == ST_RD_HOLD) begin
            r_state      <= ST_RD_BUSY;
            r_issue      <= 1'b1;
            r_issue_op   <= OP_READ;
            r_issue_data <= '0;
          end
        end

        ST_WR_BUSY: begin
          if (w_addr_edge) r_err <= 1'b1;
          if (stop_out) r_stop_pend <= 1'b1;
          if (w_timeout) begin
            r_err       <= 1'b1;
            r_skid_full <= 1'b0;
            r_stop_pend <= 1'b0;
            r_state     <= ST_IDLE;
          end else if (w_ack) begin
            r_ptr <= w_inc[AW-1:0];
            if (w_inc[AW]) r_err <= 1'b1;
            if (r_skid_full) begin
              // Drain the buffered byte back-to-back; a byte arriving now refills it.
              r_issue      <= 1'b1;
              r_issue_op   <= OP_WRITE;
              r_issue_data <= r_skid_data;
              r_skid_full  <= w_data_edge;
              if (w_data_edge) r_skid_data <= i2c_data_in;
            end else if (w_data_edge) begin
              r_issue      <= 1'b1;
              r_issue_op   <= OP_WRITE;
              r_issue_data <= i2c_data_in;
            end else if (r_stop_pend || stop_out) begin
              r_stop_pend <= 1'b0;
              r_state     <= ST_IDLE;
            end else begin
              r_state <= ST_WR_WAIT;
            end
          end else if (w_data_edge) begin
            if (r_skid_full) begin
              r_err <= 1'b1;
            end else begin
              r_skid_full <= 1'b1;
              r_skid_data <= i2c_data_in;
            end
          end
        end

        ST_RD_BUSY: begin
          if (w_addr_edge) r_err <= 1'b1;
          if (stop_out) r_stop_pend <= 1'b1;
          if (w_timeout) begin
            r_err       <= 1'b1;
            r_skid_full <= 1'b0;
            r_stop_pend <= 1'b0;
            r_state     <= ST_IDLE;
          end else if (w_ack) begin
            r_rdata  <= bus_rdata;
            r_rvalid <= 1'b1;
            r_ptr    <= w_inc[AW-1:0];
            if (w_inc[AW]) r_err <= 1'b1;
            if (r_stop_pend || stop_out) begin
              r_stop_pend <= 1'b0;
              r_state     <= ST_IDLE;
            end else begin
              r_state <= ST_RD_HOLD;
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign i2c_op       = r_op;
  assign i2c_addr_out = r_addr_out;
  assign i2c_data_out = r_data_out;
  assign i2c_xfc      = r_xfc;
  assign i2c_rdata    = r_rdata;
  assign i2c_rvalid   = r_rvalid;
  assign busy         = (r_state != ST_IDLE);
  assign err          = r_err;
endmodule

// File: tb/tb_i2c_burst_sequencer.sv
// Directed bench: a wrapping and a saturating instance driven with identical stimulus.
module tb_i2c_burst_sequencer;
  logic        Clock;
  logic        reset;
  logic        i2c_RW;
  logic [10:0] i2c_addr_in;
  logic [7:0]  i2c_data_in;
  logic        addr_xfc;
  logic        data_xfc;
  logic        stop_out;
  logic        bus_ack;
  logic [7:0]  bus_rdata;

  logic        i2c_op,   s_op;
  logic [10:0] i2c_addr_out, s_addr_out;
  logic [7:0]  i2c_data_out, s_data_out;
  logic        i2c_xfc,  s_xfc;
  logic [7:0]  i2c_rdata, s_rdata;
  logic        i2c_rvalid, s_rvalid;
  logic        busy,     s_busy;
  logic        err,      s_err;

  int checks = 0;
  int errors = 0;

  i2c_burst_sequencer #(.AW(11), .DW(8), .WRAP(1), .ACK_TIMEOUT(16)) dut (
    .Clock(Clock), .reset(reset), .i2c_RW(i2c_RW), .i2c_addr_in(i2c_addr_in),
    .i2c_data_in(i2c_data_in), .addr_xfc(addr_xfc), .data_xfc(data_xfc),
    .stop_out(stop_out), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .i2c_op(i2c_op), .i2c_addr_out(i2c_addr_out), .i2c_data_out(i2c_data_out),
    .i2c_xfc(i2c_xfc), .i2c_rdata(i2c_rdata), .i2c_rvalid(i2c_rvalid),
    .busy(busy), .err(err)
  );

  i2c_burst_sequencer #(.AW(11), .DW(8), .WRAP(0), .ACK_TIMEOUT(16)) dut_sat (
    .Clock(Clock), .reset(reset), .i2c_RW(i2c_RW), .i2c_addr_in(i2c_addr_in),
    .i2c_data_in(i2c_data_in), .addr_xfc(addr_xfc), .data_xfc(data_xfc),
    .stop_out(stop_out), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .i2c_op(s_op), .i2c_addr_out(s_addr_out), .i2c_data_out(s_data_out),
    .i2c_xfc(s_xfc), .i2c_rdata(s_rdata), .i2c_rvalid(s_rvalid),
    .busy(s_busy), .err(s_err)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic pulse_addr(input logic rw, input logic [10:0] a);
    i2c_RW = rw;
    i2c_addr_in = a;
    addr_xfc = 1'b1;
    tick();
    addr_xfc = 1'b0;
  endtask

  task automatic pulse_data(input logic [7:0] d);
    i2c_data_in = d;
    data_xfc = 1'b1;
    tick();
    data_xfc = 1'b0;
  endtask

  task automatic wait_xfc(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i2c_xfc) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic ack_after(input int dly, input logic [7:0] rd);
    repeat (dly) tick();
    bus_ack = 1'b1;
    bus_rdata = rd;
    tick();
    bus_ack = 1'b0;
    bus_rdata = 8'h00;
  endtask

  task automatic send_stop();
    stop_out = 1'b1;
    tick();
    stop_out = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    checks++;
    if ({i2c_xfc, i2c_op, i2c_rvalid, busy, err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000", {i2c_xfc, i2c_op, i2c_rvalid, busy, err});
    end
    checks++;
    if ({i2c_addr_out, i2c_data_out, i2c_rdata} !== 27'h0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", {i2c_addr_out, i2c_data_out, i2c_rdata});
    end
    reset = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_write_burst();
    bit seen;
    pulse_addr(1'b1, 11'h010);
    repeat (2) tick();
    checks++;
    if ({busy, i2c_xfc} !== 2'b10) begin
      errors++;
      $display("FAIL wr_wait_state: got busy,xfc=%b expected 10", {busy, i2c_xfc});
    end
    for (int i = 0; i < 3; i++) begin
      pulse_data(8'hA1 + 8'(i));
      wait_xfc(seen);
      checks++;
      if (!seen || i2c_op !== 1'b1 || i2c_addr_out !== 11'h010 + 11'(i) || i2c_data_out !== 8'hA1 + 8'(i)) begin
        errors++;
        $display("FAIL wr_beat%0d: got xfc=%b op=%b addr=%h data=%h expected 1 1 %h %h",
                 i, i2c_xfc, i2c_op, i2c_addr_out, i2c_data_out, 11'h010 + 11'(i), 8'hA1 + 8'(i));
      end
      tick();
      checks++;
      if (i2c_xfc !== 1'b1 || i2c_addr_out !== 11'h010 + 11'(i)) begin
        errors++;
        $display("FAIL wr_hold%0d: got xfc=%b addr=%h expected 1 %h", i, i2c_xfc, i2c_addr_out, 11'h010 + 11'(i));
      end
      ack_after(1, 8'h00);
      checks++;
      if ({i2c_xfc, err} !== 2'b00 || i2c_addr_out !== 11'h0 || i2c_data_out !== 8'h0) begin
        errors++;
        $display("FAIL wr_release%0d: got xfc=%b err=%b addr=%h data=%h expected 0 0 000 00",
                 i, i2c_xfc, err, i2c_addr_out, i2c_data_out);
      end
    end
    send_stop();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wr_stop_idle: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_read_burst();
    bit seen;
    pulse_addr(1'b0, 11'h7FE);
    tick();
    checks++;
    if (i2c_xfc !== 1'b0) begin
      errors++;
      $display("FAIL rd_latency_early: got xfc=%b expected 0", i2c_xfc);
    end
    tick();
    checks++;
    if (i2c_xfc !== 1'b1 || i2c_op !== 1'b0 || i2c_addr_out !== 11'h7FE) begin
      errors++;
      $display("FAIL rd_first: got xfc=%b op=%b addr=%h expected 1 0 7fe", i2c_xfc, i2c_op, i2c_addr_out);
    end
    ack_after(2, 8'h55);
    checks++;
    if (i2c_rvalid !== 1'b1 || i2c_rdata !== 8'h55 || i2c_xfc !== 1'b0) begin
      errors++;
      $display("FAIL rd_data0: got rvalid=%b rdata=%h xfc=%b expected 1 55 0", i2c_rvalid, i2c_rdata, i2c_xfc);
    end
    tick();
    checks++;
    if (i2c_rvalid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rd_pulse_len: got rvalid=%b busy=%b expected 0 1", i2c_rvalid, busy);
    end
    pulse_data(8'h00);
    wait_xfc(seen);
    checks++;
    if (!seen || i2c_op !== 1'b0 || i2c_addr_out !== 11'h7FF) begin
      errors++;
      $display("FAIL rd_second: got xfc=%b op=%b addr=%h expected 1 0 7ff", i2c_xfc, i2c_op, i2c_addr_out);
    end
    ack_after(2, 8'h66);
    checks++;
    if (i2c_rvalid !== 1'b1 || i2c_rdata !== 8'h66 || err !== 1'b0) begin
      errors++;
      $display("FAIL rd_data1: got rvalid=%b rdata=%h err=%b expected 1 66 0", i2c_rvalid, i2c_rdata, err);
    end
    send_stop();
  endtask

  task automatic test_wrap_saturate();
    bit seen;
    pulse_addr(1'b1, 11'h7FF);
    pulse_data(8'h11);
    wait_xfc(seen);
    checks++;
    if (!seen || i2c_addr_out !== 11'h7FF || s_addr_out !== 11'h7FF) begin
      errors++;
      $display("FAIL edge_first: got wrap=%h sat=%h expected 7ff 7ff", i2c_addr_out, s_addr_out);
    end
    ack_after(2, 8'h00);
    pulse_data(8'h22);
    wait_xfc(seen);
    checks++;
    if (!seen || i2c_addr_out !== 11'h000 || i2c_data_out !== 8'h22) begin
      errors++;
      $display("FAIL wrap_second: got addr=%h data=%h expected 000 22", i2c_addr_out, i2c_data_out);
    end
    checks++;
    if (s_xfc !== 1'b1 || s_addr_out !== 11'h7FF || s_data_out !== 8'h22) begin
      errors++;
      $display("FAIL sat_second: got xfc=%b addr=%h data=%h expected 1 7ff 22", s_xfc, s_addr_out, s_data_out);
    end
    ack_after(2, 8'h00);
    checks++;
    if (err !== 1'b0 || s_err !== 1'b1) begin
      errors++;
      $display("FAIL wrap_sat_err: got wrap_err=%b sat_err=%b expected 0 1", err, s_err);
    end
    send_stop();
  endtask

  task automatic test_skid_overrun();
    bit seen;
    pulse_addr(1'b1, 11'h100);
    pulse_data(8'hB0);
    wait_xfc(seen);
    checks++;
    if (!seen || i2c_addr_out !== 11'h100 || i2c_data_out !== 8'hB0) begin
      errors++;
      $display("FAIL skid_first: got addr=%h data=%h expected 100 b0", i2c_addr_out, i2c_data_out);
    end
    pulse_data(8'hB1);
    tick();
    pulse_data(8'hB2);
    tick();
    checks++;
    if (err !== 1'b1 || i2c_xfc !== 1'b1 || i2c_data_out !== 8'hB0) begin
      errors++;
      $display("FAIL skid_overrun: got err=%b xfc=%b data=%h expected 1 1 b0", err, i2c_xfc, i2c_data_out);
    end
    repeat (5) tick();
    ack_after(1, 8'h00);
    checks++;
    if (i2c_xfc !== 1'b0) begin
      errors++;
      $display("FAIL skid_gap: got xfc=%b expected 0", i2c_xfc);
    end
    tick();
    checks++;
    if (i2c_xfc !== 1'b1 || i2c_addr_out !== 11'h101 || i2c_data_out !== 8'hB1) begin
      errors++;
      $display("FAIL skid_b2b: got xfc=%b addr=%h data=%h expected 1 101 b1", i2c_xfc, i2c_addr_out, i2c_data_out);
    end
    ack_after(2, 8'h00);
    repeat (3) tick();
    checks++;
    if (i2c_xfc !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL skid_drop: got xfc=%b busy=%b expected 0 1", i2c_xfc, busy);
    end
    send_stop();
  endtask

  task automatic test_timeout();
    bit seen;
    int cnt;
    pulse_addr(1'b0, 11'h020);
    wait_xfc(seen);
    cnt = 0;
    while (i2c_xfc && cnt < 40) begin
      cnt++;
      tick();
    end
    checks++;
    if (!seen || cnt != 16) begin
      errors++;
      $display("FAIL timeout_len: got %0d cycles expected 16", cnt);
    end
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || i2c_addr_out !== 11'h0) begin
      errors++;
      $display("FAIL timeout_state: got err=%b busy=%b addr=%h expected 1 0 000", err, busy, i2c_addr_out);
    end
  endtask

  task automatic test_stop_busy();
    bit seen;
    pulse_addr(1'b1, 11'h030);
    pulse_data(8'hC3);
    wait_xfc(seen);
    stop_out = 1'b1;
    tick();
    stop_out = 1'b0;
    checks++;
    if (!seen || i2c_xfc !== 1'b1 || busy !== 1'b1 || i2c_addr_out !== 11'h030) begin
      errors++;
      $display("FAIL stop_hold: got xfc=%b busy=%b addr=%h expected 1 1 030", i2c_xfc, busy, i2c_addr_out);
    end
    ack_after(2, 8'h00);
    checks++;
    if (i2c_xfc !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL stop_done: got xfc=%b busy=%b err=%b expected 0 0 0", i2c_xfc, busy, err);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    int hits;
    pulse_addr(1'b1, 11'h040);
    pulse_data(8'hD4);
    wait_xfc(seen);
    reset = 1'b0;
    tick();
    checks++;
    if (!seen || {i2c_xfc, i2c_op, busy, err} !== 4'b0 || i2c_addr_out !== 11'h0 || i2c_data_out !== 8'h0) begin
      errors++;
      $display("FAIL reset_mid: got xfc=%b op=%b busy=%b err=%b addr=%h data=%h expected all 0",
               i2c_xfc, i2c_op, busy, err, i2c_addr_out, i2c_data_out);
    end
    i2c_RW = 1'b0;
    i2c_addr_in = 11'h055;
    addr_xfc = 1'b1;
    tick();
    reset = 1'b1;
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i2c_xfc || busy) hits++;
    end
    addr_xfc = 1'b0;
    checks++;
    if (hits != 0) begin
      errors++;
      $display("FAIL held_strobe: got %0d active cycles expected 0", hits);
    end
  endtask

  initial begin
    reset = 1'b0;
    i2c_RW = 1'b0;
    i2c_addr_in = '0;
    i2c_data_in = '0;
    addr_xfc = 1'b0;
    data_xfc = 1'b0;
    stop_out = 1'b0;
    bus_ack = 1'b0;
    bus_rdata = '0;
    test_reset();
    test_write_burst();
    test_read_burst();
    test_wrap_saturate();
    test_skid_overrun();
    test_timeout();
    test_stop_busy();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end
endmodule
